sr_latch_sequencer: RTL and testbench

- Arbitrates set/clear requests from NREQ requesters onto one shared SR latch (ports s, r, q, qbar) and sequences each access as a timed drive pulse, a settle gap and a readback check.
- Guarantees the latch never sees s=1 and r=1 together.
- Sits between the control logic and the latch instance.
- Reports per-requester completion (gnt) and a sticky readback error.

---
 rtl/sr_latch_sequencer.sv | 136 +++++++++++++
 tb/tb_sr_latch_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_sequencer.sv
// Round-robin sequencer driving one shared SR latch: drive pulse, settle gap, readback check, per-requester gnt.
// Latency: gnt in the 1+PULSE_CYC+SETTLE_CYC-th cycle after acceptance (1st cycle with SR_SKIP_REDUNDANT_EN on a redundant op).
// Backpressure: requesters hold req until their one-cycle gnt; requests seen while busy wait for the next IDLE.
module sr_latch_sequencer #(
  parameter int NREQ       = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  input  logic            q_in,
  input  logic            qbar_in,
  input  logic            err_clr,
  output logic            s,
  output logic            r,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            err
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   cur_id_q;
  logic            cur_op_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;

  logic            win_vld;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   idx_b;
  logic            win_op;
  logic            chk_fail;
  logic            skip;
  logic            err_d;
  logic [IW-1:0]   ptr_d;
  int              idx;

  // First requester at or after the pointer, wrapping past NREQ-1.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    idx_b   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_b = IW'(idx);
      if (!win_vld && req[idx_b]) begin
        win_vld = 1'b1;
        win_id  = idx_b;
      end
    end
  end

  always_comb begin
    win_op   = op[win_id];
    chk_fail = (q_in != cur_op_q) || (q_in == qbar_in);
`ifdef SR_SKIP_REDUNDANT_EN
    skip     = (win_op == q_in) && (q_in != qbar_in);
`else
    skip     = 1'b0;
`endif
    // A failing readback outranks a same-cycle clear request.
    err_d    = ((state_q == ST_CHECK) && chk_fail) || (err_q && !err_clr);
    ptr_d    = (cur_id_q == IW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cur_id_q <= '0;
      cur_op_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            cur_id_q <= win_id;
            cur_op_q <= win_op;
            if (skip) begin
              state_q <= ST_CHECK;
            end else begin
              cnt_q   <= CW'(PULSE_CYC - 1);
              state_q <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            cnt_q   <= CW'(SETTLE_CYC - 1);
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          ptr_q   <= ptr_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so s and r can never overlap.
  always_comb begin
    s    = (state_q == ST_DRIVE) && cur_op_q;
    r    = (state_q == ST_DRIVE) && !cur_op_q;
    busy = (state_q != ST_IDLE);
    gnt  = '0;
    if (state_q == ST_CHECK) gnt[cur_id_q] = 1'b1;
  end

  assign err = err_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Bench for sr_latch_sequencer: latch model, gnt scoreboard, vector table and hand-written corner sequences.
// Expectations adapt to SR_SKIP_REDUNDANT_EN when that macro is defined.
module tb_sr_latch_sequencer;

  localparam int NREQ = 4;
  localparam int P    = 2;
  localparam int S    = 1;
`ifdef SR_SKIP_REDUNDANT_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] op;
  logic            q_in;
  logic            qbar_in;
  logic            err_clr;
  logic            s;
  logic            r;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic            err;

  sr_latch_sequencer #(.NREQ(NREQ), .PULSE_CYC(P), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .q_in(q_in), .qbar_in(qbar_in),
    .err_clr(err_clr), .s(s), .r(r), .gnt(gnt), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Latch model; stuck mode overrides the feedback seen by the DUT.
  logic lq = 1'b0;
  logic stuck = 1'b0;
  logic stuck_q = 1'b0;
  logic stuck_qb = 1'b1;
  always @(posedge clk) begin
    if (s)      lq <= 1'b1;
    else if (r) lq <= 1'b0;
  end
  assign q_in    = stuck ? stuck_q  : lq;
  assign qbar_in = stuck ? stuck_qb : ~lq;

  int checks = 0;
  int errors = 0;
  logic [NREQ-1:0] sb[$];
  logic exp_q  = 1'b0;
  logic exp_qv = 1'b1;
  int   run    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int exp_lat(input logic ob);
    int l;
    l = 1 + P + S;
    if (SKIP && exp_qv && (ob == exp_q)) l = 1;
    return l;
  endfunction

  // Scoreboard and invariant monitor.
  always @(negedge clk) begin
    logic [NREQ-1:0] e;
    check("s_r_overlap", {31'd0, s & r}, 32'd0);
    if (!rst_n) run = 0;
    else if (s || r) run++;
    else if (run != 0) begin
      check("pulse_len", run, P);
      run = 0;
    end
    if (gnt != '0) begin
      if (sb.size() == 0) begin
        check("gnt_unexpected", {28'd0, gnt}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("gnt_order", {28'd0, gnt}, {28'd0, e});
      end
    end
  end

  // Called just after a negedge with the DUT in IDLE; returns at the gnt negedge.
  task automatic run_access(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] opv,
                            input logic [NREQ-1:0] eg, input bit keep);
    logic       opbit;
    int         lat;
    logic [3:0] expv;
    req = rq;
    op  = opv;
    sb.push_back(eg);
    opbit = |(opv & eg);
    lat   = exp_lat(opbit);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      expv = {(lat > 1) && (c <= P) && opbit, (lat > 1) && (c <= P) && !opbit, 1'b1, c == lat};
      check($sformatf("access_c%0d", c), {28'd0, s, r, busy, gnt != '0}, {28'd0, expv});
      if (c == lat && !keep) req = '0;
    end
    exp_q  = opbit;
    exp_qv = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_sr_busy", {29'd0, s, r, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NREQ-1:0] rq;
    logic [NREQ-1:0] opv;
    logic [NREQ-1:0] eg;
    logic            q;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 1'b0};
    tbl[1] = '{4'b0010, 4'b0010, 4'b0010, 1'b1};
    tbl[2] = '{4'b1001, 4'b1000, 4'b1000, 1'b1};
    tbl[3] = '{4'b0110, 4'b0000, 4'b0010, 1'b0};
    tbl[4] = '{4'b0011, 4'b0001, 4'b0001, 1'b1};
    tbl[5] = '{4'b0101, 4'b0100, 4'b0100, 1'b1};
    tbl[6] = '{4'b1010, 4'b0000, 4'b1000, 1'b0};
    tbl[7] = '{4'b1100, 4'b1111, 4'b0100, 1'b1};

    // Reset with a pending set request.
    rst_n = 1'b0; req = 4'b0001; op = 4'b0001; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_sr", {30'd0, s, r}, 32'd0);
    check("reset_gnt_busy_err", {26'd0, gnt, busy, err}, 32'd0);
    rst_n = 1'b1;
    run_access(4'b0001, 4'b0001, 4'b0001, 1'b0);
    @(negedge clk);
    check("reset_access_q", {31'd0, q_in}, 32'd1);
    check("reset_access_err", {31'd0, err}, 32'd0);

    // All requesters held: full rotation from pointer 0.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_access(4'b1111, 4'b0101, 4'(1 << (i % 4)), i < 4);
      @(negedge clk);
      check("rr_idle_gap", {31'd0, busy}, 32'd0);
    end

    // Vector table; pointer starts at 1.
    for (int i = 0; i < 8; i++) begin
      run_access(tbl[i].rq, tbl[i].opv, tbl[i].eg, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_q", i), {31'd0, q_in}, {31'd0, tbl[i].q});
      check($sformatf("vec%0d_err", i), {31'd0, err}, 32'd0);
    end

    // Set on requester 2 while q is already 1.
    run_access(4'b0100, 4'b0100, 4'b0100, 1'b0);
    @(negedge clk);

    // Reset during the second drive cycle aborts the access.
    req = 4'b0010; op = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    check("abort_drive1_r", {30'd0, s, r}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_sr_drop", {29'd0, s, r, busy}, 32'd0);
    @(negedge clk);
    check("abort_no_gnt", {28'd0, gnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = 1'b0;
    run_access(4'b0010, 4'b0000, 4'b0010, 1'b0);
    @(negedge clk);
    check("abort_restart_q", {31'd0, q_in}, 32'd0);

    // Readback failures and err_clr interaction.
    stuck = 1'b1; stuck_q = 1'b0; stuck_qb = 1'b1;
    exp_q = 1'b0;
    run_access(4'b0001, 4'b0001, 4'b0001, 1'b0);
    @(negedge clk);
    check("err_set", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", {31'd0, err}, 32'd0);
    exp_q = 1'b0;
    run_access(4'b0001, 4'b0001, 4'b0001, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_fail_beats_clr", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared2", {31'd0, err}, 32'd0);
    stuck_q = 1'b1; stuck_qb = 1'b1;
    exp_q = 1'b1; exp_qv = 1'b0;
    run_access(4'b0010, 4'b0010, 4'b0010, 1'b0);
    @(negedge clk);
    check("err_q_eq_qbar", {31'd0, err}, 32'd1);

    // err stays set across a passing access.
    stuck = 1'b0;
    exp_q = 1'b1; exp_qv = 1'b1;
    run_access(4'b0100, 4'b0000, 4'b0100, 1'b0);
    @(negedge clk);
    check("err_sticky", {31'd0, err}, 32'd1);
    check("final_q", {31'd0, q_in}, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
